traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Passive checker on the RGB lamp lines driven by the traffic light controller.
//  Decodes the lamp colour each clock and locks onto the light's phase sequence.
//  Checks the sequence RED -> YELLOW -> GREEN -> YELLOW -> RED and the dwell time of each phase.
//  Reports decoded phase, lock status, cycle completion and error code/count; used in bench and on-board.
// PARAMETERS
//  RED_LEN  10  required RED dwell, clock cycles
//  Y1_LEN   2   required YELLOW dwell after RED
//  GRN_LEN  8   required GREEN dwell
//  Y2_LEN   5   required YELLOW dwell after GREEN
//  CW       5   run-length counter width; must hold max(*_LEN)+1
//  ECW      8   error counter width
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    reset, asynchronous, active-high
//  red         in   1    lamp line, synchronous to clk
//  green       in   1    lamp line, synchronous to clk
//  blue        in   1    lamp line, synchronous to clk; must never be lit
//  phase       out  2    decoded colour: 00 OFF, 01 RED, 10 YELLOW, 11 GREEN
//  locked      out  1    high while tracking a valid sequence
//  cycle_done  out  1    1-cycle pulse on each correct Y2 -> RED transition
//  run_len     out  CW   consecutive cycles of the current colour, incl. this one
//  err         out  1    1-cycle pulse on each detected error
//  err_code    out  3    last error: 0 none, 1 too short, 2 too long, 3 bad sequence, 4 illegal colour
//  err_count   out  ECW  number of errors, saturating at all-ones
// BEHAVIOUR
//  Reset: all outputs 0; FSM = HUNT; previous colour = OFF.
//    Async assert clears immediately; release takes effect on the next clk edge.
//  Decode: r,g,b = 1,0,0 RED; 1,1,0 YELLOW; 0,1,0 GREEN; 0,0,0 OFF; any blue = ILLEGAL.
//    phase shows 00 when ILLEGAL.
//  Latency: lines sampled at edge k; every output reflects that sample right after edge k.
//    err and cycle_done are high for exactly that one cycle.
//  run_len: 1 on the first cycle of a new colour, +1 per repeated cycle, saturates at all-ones.
//  FSM states: HUNT, S_RED, S_Y1, S_GRN, S_Y2. locked = (state != HUNT).
//  HUNT -> S_RED when colour = RED and previous colour != RED (red entry).
//    A mid-red start never locks.
//  In S_X with length L_X and successor colour N_X:
//    - colour X, run_len < L_X: stay.
//    - colour X, run_len == L_X: err, code 2 (too long), -> HUNT.
//    - colour N_X, run_len == L_X: advance to the next state.
//      From S_Y2 the next state is S_RED, and cycle_done pulses.
//    - colour N_X, run_len < L_X: err, code 1 (too short), -> HUNT.
//    - any other legal non-OFF colour: err, code 3, -> HUNT.
//    - OFF: -> HUNT, no error (controller disabled).
//  ILLEGAL in any state, including HUNT: err, code 4, -> HUNT.
//    This has priority over all other checks.
//  err_code holds until the next error or reset; err_count +1 per err pulse.
//  After an error the same cycle cannot relock. Relock needs a fresh red entry.
// TESTING
//  1. Reset, then 3 nominal cycles R10/Y2/G8/Y5 followed by R.
//     -> locked from the first red cycle; cycle_done 3 pulses; err never set.
//  2. Lock, then hold RED 11 cycles.
//     -> err on the 11th red cycle, err_code=2, err_count=1, locked=0.
//     -> Relocks at the next red entry.
//  3. Lock, then GREEN 7 cycles, then YELLOW.
//     -> err on the first yellow cycle, err_code=1.
//  4. Lock, then RED 10 cycles, then GREEN directly.
//     -> err on the first green cycle, err_code=3.
//  5. blue=1 for one cycle in S_GRN, and again in HUNT.
//     -> err each time, err_code=4, phase=00; err_count=2.
//  6a. Assert rst mid-GREEN with no clock edge.
//     -> all outputs 0 immediately.
//  6b. Release rst while GREEN is lit.
//     -> locked stays 0 until RED entry.
//  6c. With ECW=2, inject 5 errors.
//     -> err_count=3.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive checker on the RGB lamp lines of a traffic light controller.
//   Decodes the lamp colour every clock, locks onto the phase sequence
//   RED -> YELLOW -> GREEN -> YELLOW -> RED and checks each phase's dwell.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   red/green/blue  lamp lines, synchronous to clk (blue must never be lit)
//   phase       decoded colour: 00 OFF / ILLEGAL, 01 RED, 10 YELLOW, 11 GREEN
//   locked      high while tracking a valid sequence
//   cycle_done  one-cycle pulse on each correct Y2 -> RED transition
//   run_len     consecutive cycles of the current colour, including this one
//   err         one-cycle pulse on each detected error
//   err_code    last error: 0 none, 1 too short, 2 too long, 3 bad sequence,
//               4 illegal colour
//   err_count   number of errors, saturating at all-ones
//
// state | meaning
// ------+-----------------------------------------------------------
// HUNT  | not locked; waiting for a fresh red entry
// S_RED | locked, in the red phase
// S_Y1  | locked, in the yellow phase that follows red
// S_GRN | locked, in the green phase
// S_Y2  | locked, in the yellow phase that follows green

module traffic_light_monitor #(
   parameter int RED_LEN = 10,
   parameter int Y1_LEN  = 2,
   parameter int GRN_LEN = 8,
   parameter int Y2_LEN  = 5,
   parameter int CW      = 5,
   parameter int ECW     = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           red,
   input  logic           green,
   input  logic           blue,
   output logic [1:0]     phase,
   output logic           locked,
   output logic           cycle_done,
   output logic [CW-1:0]  run_len,
   output logic           err,
   output logic [2:0]     err_code,
   output logic [ECW-1:0] err_count
);

   typedef enum logic [2:0] {
      C_OFF = 3'd0,
      C_RED = 3'd1,
      C_YEL = 3'd2,
      C_GRN = 3'd3,
      C_ILL = 3'd4
   } colour_t;

   typedef enum logic [2:0] {
      HUNT  = 3'd0,
      S_RED = 3'd1,
      S_Y1  = 3'd2,
      S_GRN = 3'd3,
      S_Y2  = 3'd4
   } state_t;

   // Per-sample classification, shared by the next-state and output logic.
   typedef enum logic [3:0] {
      EV_STAY  = 4'd0,
      EV_ENTRY = 4'd1,
      EV_ADV   = 4'd2,
      EV_SHORT = 4'd3,
      EV_LONG  = 4'd4,
      EV_SEQ   = 4'd5,
      EV_ILL   = 4'd6,
      EV_OFF   = 4'd7
   } event_t;

   localparam logic [CW-1:0] RED_L = CW'(RED_LEN);
   localparam logic [CW-1:0] Y1_L  = CW'(Y1_LEN);
   localparam logic [CW-1:0] GRN_L = CW'(GRN_LEN);
   localparam logic [CW-1:0] Y2_L  = CW'(Y2_LEN);
   localparam logic [CW-1:0] RL_ONE = CW'(1);
   localparam logic [CW-1:0] RL_MAX = {CW{1'b1}};
   localparam logic [ECW-1:0] EC_MAX = {ECW{1'b1}};

   state_t          state, nxt_state;
   colour_t         colour, prev_colour;
   event_t          ev;

   colour_t         cur_col, succ_col;
   logic [CW-1:0]   cur_len;
   state_t          after_state;

   logic [CW-1:0]   run_len_q, run_len_nxt;
   logic [1:0]      phase_q, phase_nxt;
   logic            err_q, err_nxt;
   logic [2:0]      code_q, code_nxt;
   logic [ECW-1:0]  cnt_q;
   logic            done_q, done_nxt;

   // ---------------------------------------------------------------
   // Colour decode; any blue light wins over everything else.
   // ---------------------------------------------------------------
   always_comb begin
      colour = C_OFF;
      if (blue)
         colour = C_ILL;
      else if (red && green)
         colour = C_YEL;
      else if (red)
         colour = C_RED;
      else if (green)
         colour = C_GRN;
   end

   always_comb begin
      phase_nxt = 2'b00;
      case (colour)
         C_RED:   phase_nxt = 2'b01;
         C_YEL:   phase_nxt = 2'b10;
         C_GRN:   phase_nxt = 2'b11;
         default: phase_nxt = 2'b00;
      endcase
   end

   // Run length of the colour just sampled.
   always_comb begin
      if (colour == prev_colour)
         run_len_nxt = (run_len_q == RL_MAX) ? run_len_q : run_len_q + RL_ONE;
      else
         run_len_nxt = RL_ONE;
   end

   // ---------------------------------------------------------------
   // Phase parameters of the current state: own colour, successor
   // colour, required dwell and the state reached on a clean advance.
   // ---------------------------------------------------------------
   always_comb begin
      cur_col     = C_OFF;
      succ_col    = C_OFF;
      cur_len     = '0;
      after_state = HUNT;
      case (state)
         S_RED: begin
            cur_col = C_RED; succ_col = C_YEL; cur_len = RED_L; after_state = S_Y1;
         end
         S_Y1: begin
            cur_col = C_YEL; succ_col = C_GRN; cur_len = Y1_L;  after_state = S_GRN;
         end
         S_GRN: begin
            cur_col = C_GRN; succ_col = C_YEL; cur_len = GRN_L; after_state = S_Y2;
         end
         S_Y2: begin
            cur_col = C_YEL; succ_col = C_RED; cur_len = Y2_L;  after_state = S_RED;
         end
         default: begin
            cur_col = C_OFF; succ_col = C_OFF; cur_len = '0;    after_state = HUNT;
         end
      endcase
   end

   // run_len_q still holds the dwell before this sample, so reaching the
   // required length means the phase is complete and may not continue.
   always_comb begin
      ev = EV_STAY;
      if (colour == C_ILL)
         ev = EV_ILL;
      else if (state == HUNT)
         ev = (colour == C_RED && prev_colour != C_RED) ? EV_ENTRY : EV_STAY;
      else if (colour == C_OFF)
         ev = EV_OFF;
      else if (colour == cur_col)
         ev = (run_len_q == cur_len) ? EV_LONG : EV_STAY;
      else if (colour == succ_col)
         ev = (run_len_q == cur_len) ? EV_ADV : EV_SHORT;
      else
         ev = EV_SEQ;
   end

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= HUNT;
      else
         state <= nxt_state;
   end

   // FSM: next state
   always_comb begin
      nxt_state = state;
      case (ev)
         EV_ENTRY: nxt_state = S_RED;
         EV_STAY:  nxt_state = state;
         EV_ADV:   nxt_state = after_state;
         default:  nxt_state = HUNT;
      endcase
   end

   // FSM: outputs for this sample
   always_comb begin
      err_nxt  = 1'b0;
      code_nxt = code_q;
      done_nxt = 1'b0;
      case (ev)
         EV_SHORT: begin err_nxt = 1'b1; code_nxt = 3'd1; end
         EV_LONG:  begin err_nxt = 1'b1; code_nxt = 3'd2; end
         EV_SEQ:   begin err_nxt = 1'b1; code_nxt = 3'd3; end
         EV_ILL:   begin err_nxt = 1'b1; code_nxt = 3'd4; end
         EV_ADV:   done_nxt = (state == S_Y2);
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // Registered report outputs
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_colour <= C_OFF;
         run_len_q   <= '0;
         phase_q     <= 2'b00;
         err_q       <= 1'b0;
         code_q      <= 3'd0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         prev_colour <= colour;
         run_len_q   <= run_len_nxt;
         phase_q     <= phase_nxt;
         err_q       <= err_nxt;
         code_q      <= code_nxt;
         done_q      <= done_nxt;
         if (err_nxt && cnt_q != EC_MAX)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign phase      = phase_q;
   assign locked     = (state != HUNT);
   assign cycle_done = done_q;
   assign run_len    = run_len_q;
   assign err        = err_q;
   assign err_code   = code_q;
   assign err_count  = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

   localparam logic [2:0] R  = 3'b100;   // {red, green, blue}
   localparam logic [2:0] Y  = 3'b110;
   localparam logic [2:0] G  = 3'b010;
   localparam logic [2:0] O  = 3'b000;
   localparam logic [2:0] BL = 3'b001;
   localparam logic [2:0] GB = 3'b011;

   logic       clk, rst, red, green, blue;
   logic [1:0] phase;
   logic       locked, cycle_done, err;
   logic [4:0] run_len;
   logic [2:0] err_code;
   logic [7:0] err_count;

   logic [1:0] phase2;
   logic       locked2, cycle_done2, err2;
   logic [4:0] run_len2;
   logic [2:0] err_code2;
   logic [1:0] err_count2;

   traffic_light_monitor dut (
      .clk(clk), .rst(rst), .red(red), .green(green), .blue(blue),
      .phase(phase), .locked(locked), .cycle_done(cycle_done),
      .run_len(run_len), .err(err), .err_code(err_code), .err_count(err_count)
   );

   traffic_light_monitor #(.ECW(2)) dut2 (
      .clk(clk), .rst(rst), .red(red), .green(green), .blue(blue),
      .phase(phase2), .locked(locked2), .cycle_done(cycle_done2),
      .run_len(run_len2), .err(err2), .err_code(err_code2), .err_count(err_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] col;
      logic       lk;
      logic       dn;
      logic       e;
      logic [2:0] code;
      logic [7:0] cnt;
      logic [4:0] rl;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;
   logic [2:0] ecode;
   logic [7:0] ecnt;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want)
         passes++;
      else
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
   endtask

   function automatic logic [1:0] exp_phase(input logic [2:0] c);
      if (c[0])             return 2'b00;
      if (c[2] && c[1])     return 2'b10;
      if (c[2])             return 2'b01;
      if (c[1])             return 2'b11;
      return 2'b00;
   endfunction

   // Drive one sample and queue the expected report for it.
   task automatic cyc(input logic [2:0] col, input logic lk, input logic dn,
                      input logic e, input logic [4:0] rl);
      exp_t x;
      @(negedge clk);
      {red, green, blue} = col;
      x.col = col; x.lk = lk; x.dn = dn; x.e = e;
      x.code = ecode; x.cnt = ecnt; x.rl = rl;
      q.push_back(x);
   endtask

   task automatic nom(input logic done_first);
      for (int i = 1; i <= 10; i++) cyc(R, 1'b1, (i == 1) && done_first, 1'b0, 5'(i));
      for (int i = 1; i <= 2;  i++) cyc(Y, 1'b1, 1'b0, 1'b0, 5'(i));
      for (int i = 1; i <= 8;  i++) cyc(G, 1'b1, 1'b0, 1'b0, 5'(i));
      for (int i = 1; i <= 5;  i++) cyc(Y, 1'b1, 1'b0, 1'b0, 5'(i));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " phase"},      32'(phase),      0);
      chk({tag, " locked"},     32'(locked),     0);
      chk({tag, " cycle_done"}, 32'(cycle_done), 0);
      chk({tag, " run_len"},    32'(run_len),    0);
      chk({tag, " err"},        32'(err),        0);
      chk({tag, " err_code"},   32'(err_code),   0);
      chk({tag, " err_count"},  32'(err_count),  0);
      chk({tag, " err_count2"}, 32'(err_count2), 0);
   endtask

   // Monitor: after every rising edge, compare against the queued entry.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            x = q.pop_front();
            chk("phase",      32'(phase),      32'(exp_phase(x.col)));
            chk("locked",     32'(locked),     32'(x.lk));
            chk("cycle_done", 32'(cycle_done), 32'(x.dn));
            chk("err",        32'(err),        32'(x.e));
            chk("err_code",   32'(err_code),   32'(x.code));
            chk("err_count",  32'(err_count),  32'(x.cnt));
            chk("run_len",    32'(run_len),    32'(x.rl));
            chk("err_count_sat", 32'(err_count2), (x.cnt > 8'd3) ? 32'd3 : 32'(x.cnt));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; red = 1'b0; green = 1'b0; blue = 1'b0;
      ecode = 3'd0; ecnt = 8'd0;
      #3;
      chk_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Nominal cycles
      nom(1'b0);
      nom(1'b1);
      nom(1'b1);
      cyc(R, 1'b1, 1'b1, 1'b0, 5'd1);

      // Red held too long, no relock mid-red, relock on fresh entry
      for (int i = 2; i <= 10; i++) cyc(R, 1'b1, 1'b0, 1'b0, 5'(i));
      ecode = 3'd2; ecnt = 8'd1;
      cyc(R, 1'b0, 1'b0, 1'b1, 5'd11);
      cyc(R, 1'b0, 1'b0, 1'b0, 5'd12);
      cyc(O, 1'b0, 1'b0, 1'b0, 5'd1);
      cyc(R, 1'b1, 1'b0, 1'b0, 5'd1);

      // Green too short
      for (int i = 2; i <= 10; i++) cyc(R, 1'b1, 1'b0, 1'b0, 5'(i));
      for (int i = 1; i <= 2;  i++) cyc(Y, 1'b1, 1'b0, 1'b0, 5'(i));
      for (int i = 1; i <= 7;  i++) cyc(G, 1'b1, 1'b0, 1'b0, 5'(i));
      ecode = 3'd1; ecnt = 8'd2;
      cyc(Y, 1'b0, 1'b0, 1'b1, 5'd1);
      cyc(O, 1'b0, 1'b0, 1'b0, 5'd1);

      // Red straight to green
      for (int i = 1; i <= 10; i++) cyc(R, 1'b1, 1'b0, 1'b0, 5'(i));
      ecode = 3'd3; ecnt = 8'd3;
      cyc(G, 1'b0, 1'b0, 1'b1, 5'd1);
      cyc(O, 1'b0, 1'b0, 1'b0, 5'd1);

      // Blue lit while in green, then again in HUNT
      for (int i = 1; i <= 10; i++) cyc(R, 1'b1, 1'b0, 1'b0, 5'(i));
      for (int i = 1; i <= 2;  i++) cyc(Y, 1'b1, 1'b0, 1'b0, 5'(i));
      for (int i = 1; i <= 3;  i++) cyc(G, 1'b1, 1'b0, 1'b0, 5'(i));
      ecode = 3'd4; ecnt = 8'd4;
      cyc(GB, 1'b0, 1'b0, 1'b1, 5'd1);
      cyc(G, 1'b0, 1'b0, 1'b0, 5'd1);
      ecnt = 8'd5;
      cyc(BL, 1'b0, 1'b0, 1'b1, 5'd1);

      // Lock again, then asynchronous reset mid-green
      cyc(O, 1'b0, 1'b0, 1'b0, 5'd1);
      for (int i = 1; i <= 10; i++) cyc(R, 1'b1, 1'b0, 1'b0, 5'(i));
      for (int i = 1; i <= 2;  i++) cyc(Y, 1'b1, 1'b0, 1'b0, 5'(i));
      for (int i = 1; i <= 3;  i++) cyc(G, 1'b1, 1'b0, 1'b0, 5'(i));
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");

      // Release with green lit: no lock until a red entry
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ecode = 3'd0; ecnt = 8'd0;
      cyc(G, 1'b0, 1'b0, 1'b0, 5'd2);
      cyc(G, 1'b0, 1'b0, 1'b0, 5'd3);
      cyc(R, 1'b1, 1'b0, 1'b0, 5'd1);
      cyc(R, 1'b1, 1'b0, 1'b0, 5'd2);

      repeat (3) @(posedge clk);
      #4;
      if (q.size() != 0) begin
         checks++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
